// File: rtl/vec_serial_mac_if.sv
// Handshake bundle for vec_serial_mac: vector-pair input channel, scalar
// result output channel and the busy flag.
// The producer/consumer side uses modport master; the MAC uses modport slave.
interface vec_serial_mac_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int OW = 2*DW + $clog2(N);

    logic            in_valid;
    logic            in_ready;
    logic [DW*N-1:0] in_a;
    logic [DW*N-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic            busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/vec_serial_mac.sv
// vec_serial_mac: serial dot product of two packed N-element vectors.
// One element pair is multiply-accumulated per clock; the scalar result is
// presented on a valid/ready output and held under backpressure.
// Optional build macro VEC_MAC_SIGNED_EN: elements are two's complement and
// products are sign-extended; otherwise everything is unsigned.
module vec_serial_mac #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    vec_serial_mac_if.slave bus
);
    localparam int OW = 2*DW + $clog2(N);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic [OW-1:0]   acc;
    logic [OW-1:0]   out_q;
    logic [DW*N-1:0] a_q, b_q;
    logic [OW-1:0]   prod;
    logic [OW-1:0]   sum;
    logic            last;

    // Element product widened to the accumulator width; extension kind
    // follows the arithmetic mode so the OW-bit sum never wraps.
    function automatic logic [OW-1:0] elem_product(input logic [DW-1:0] a,
                                                   input logic [DW-1:0] b);
`ifdef VEC_MAC_SIGNED_EN
        logic signed [DW-1:0]   sa;
        logic signed [DW-1:0]   sb;
        logic signed [2*DW-1:0] p;
        sa = a;
        sb = b;
        p  = sa * sb;
        return {{(OW-2*DW){p[2*DW-1]}}, p};
`else
        logic [2*DW-1:0] p;
        p = a * b;
        return {{(OW-2*DW){1'b0}}, p};
`endif
    endfunction

    // Next-state decode and the running sum for the current element pair.
    always_comb begin
        state_nx = state;
        last     = (idx == LAST_IDX);
        prod     = elem_product(a_q[idx*DW +: DW], b_q[idx*DW +: DW]);
        sum      = acc + prod;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register; reset forces IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operand capture, accumulation and result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            acc   <= '0;
            out_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q <= bus.in_a;
                        b_q <= bus.in_b;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                RUN: begin
                    acc <= sum;
                    idx <= idx + IW'(1);
                    if (last) out_q <= sum;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = out_q;
endmodule

// File: tb/tb_vec_serial_mac.sv
// Self-checking bench for vec_serial_mac: directed cases plus randomized
// vector pairs compared against a plain-arithmetic dot-product model.
module tb_vec_serial_mac;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 2*DW + $clog2(N);

    logic tb_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    vec_serial_mac_if #(.N(N), .DW(DW)) bus ();

    vec_serial_mac #(.N(N), .DW(DW)) dut (
        .clk   (tb_clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: sum of element products computed with 64-bit integers.
    function automatic logic [OW-1:0] ref_dot(input logic [DW*N-1:0] a,
                                              input logic [DW*N-1:0] b);
        longint s;
        longint ea;
        longint eb;
        s = 0;
        for (int i = 0; i < N; i++) begin
`ifdef VEC_MAC_SIGNED_EN
            ea = longint'($signed(a[i*DW +: DW]));
            eb = longint'($signed(b[i*DW +: DW]));
`else
            ea = longint'(a[i*DW +: DW]);
            eb = longint'(b[i*DW +: DW]);
`endif
            s = s + ea * eb;
        end
        return s[OW-1:0];
    endfunction

    function automatic logic [DW*N-1:0] rand_vec();
        logic [DW*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Offer one vector pair, check latency and result, apply hold cycles of
    // backpressure (with noise on the input channel), then hand off.
    task automatic run_txn(input string tag, input logic [DW*N-1:0] a,
                           input logic [DW*N-1:0] b, input logic [OW-1:0] exp,
                           input int hold);
        int wait_cnt;
        int lat;
        @(negedge tb_clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        wait_cnt = 0;
        while (!bus.in_ready && wait_cnt < 30) begin
            @(negedge tb_clk);
            wait_cnt++;
        end
        if (!bus.in_ready) check_val({tag, "_accept_timeout"}, 0, 1);
        @(posedge tb_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = rand_vec();
        bus.in_b     = rand_vec();
        check_val({tag, "_ready_low"}, 64'(bus.in_ready), 0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            bus.in_valid = 1'($urandom);
            bus.in_a     = rand_vec();
            @(posedge tb_clk);
            #1;
            lat++;
        end
        check_val({tag, "_latency"}, 64'(lat), 64'(N));
        check_val({tag, "_data"}, 64'(bus.out_data), 64'(exp));
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = 1'($urandom);
            bus.in_a     = rand_vec();
            @(posedge tb_clk);
            #1;
            check_val({tag, "_hold_valid"}, 64'(bus.out_valid), 1);
            check_val({tag, "_hold_data"}, 64'(bus.out_data), 64'(exp));
            check_val({tag, "_hold_busy"}, 64'(bus.busy), 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge tb_clk);
        #1;
        bus.out_ready = 1'b0;
        check_val({tag, "_valid_drop"}, 64'(bus.out_valid), 0);
        check_val({tag, "_ready_back"}, 64'(bus.in_ready), 1);
    endtask

    initial begin
        logic [DW*N-1:0] a;
        logic [DW*N-1:0] b;
        logic [OW-1:0]   exp;
        int              seen;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge tb_clk);
        #2;
        rst_n = 1'b1;

        // Load a result so out_data is nonzero, then reset asynchronously
        // mid-RUN on a later transaction.
        run_txn("pre", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 70, 0);
        @(negedge tb_clk);
        bus.in_a = {8'd9, 8'd9, 8'd9, 8'd9};
        bus.in_b = {8'd9, 8'd9, 8'd9, 8'd9};
        bus.in_valid = 1'b1;
        @(posedge tb_clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge tb_clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", 64'(bus.out_valid), 0);
        check_val("rst_out_data", 64'(bus.out_data), 0);
        check_val("rst_busy", 64'(bus.busy), 0);
        check_val("rst_in_ready", 64'(bus.in_ready), 1);
        @(negedge tb_clk);
        rst_n = 1'b1;
        repeat (3) @(posedge tb_clk);
        #1;
        check_val("idle_out_valid", 64'(bus.out_valid), 0);
        check_val("idle_out_data", 64'(bus.out_data), 0);
        check_val("idle_busy", 64'(bus.busy), 0);
        check_val("idle_in_ready", 64'(bus.in_ready), 1);

        // Directed cases.
        run_txn("basic", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 70, 0);
`ifdef VEC_MAC_SIGNED_EN
        run_txn("max", {N{8'hFF}}, {N{8'hFF}}, 18'd4, 0);
        run_txn("mixed", {N{8'hFF}}, {N{8'h02}}, 18'h3FFF8, 0);
        run_txn("minneg", {N{8'h80}}, {N{8'h80}}, 18'h10000, 0);
`else
        run_txn("max", {N{8'hFF}}, {N{8'hFF}}, 18'h3F804, 0);
        run_txn("mixed", {N{8'hFF}}, {N{8'h02}}, 18'd2040, 0);
`endif
        run_txn("bp", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 70, 10);

        // Reset pulse while RUN is on element index 2.
        @(negedge tb_clk);
        bus.in_a = {8'd40, 8'd30, 8'd20, 8'd10};
        bus.in_b = {8'd1, 8'd2, 8'd3, 8'd4};
        bus.in_valid = 1'b1;
        @(posedge tb_clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge tb_clk);
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge tb_clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check_val("midrun_no_valid", 64'(seen), 0);
        run_txn("after_rst", {N{8'd1}}, {N{8'd2}}, 8, 0);

        // Randomized pairs against the reference model.
        for (int t = 0; t < 40; t++) begin
            a = rand_vec();
            b = rand_vec();
            if (t % 10 == 3) a = {N{8'hFF}};
            if (t % 10 == 7) b = {N{8'h80}};
            exp = ref_dot(a, b);
            run_txn($sformatf("rnd%0d", t), a, b, exp, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
